// File: rtl/axis_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : axis_fifo_pkg
// Brief   : Shared defaults, data type and pointer-width helper for axis_fifo.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axis_fifo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;

  // One extra MSB beyond the address lets equal addresses mean full or empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_fifo_ram.sv
//------------------------------------------------------------------------------
// Module  : axis_fifo_ram
// Brief   : DEPTH x DATA_W register array, sync write, registered sync read.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ptr_w(DEPTH) - 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_fifo_core.sv
//------------------------------------------------------------------------------
// Module  : axis_fifo_core
// Brief   : Single-clock registered-read FIFO with empty/almost-full flags.
//           Define AXIS_FIFO_OVF_FLAG_EN to add the sticky fifo_ovf output.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_fifo_core
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_afull
`ifdef AXIS_FIFO_OVF_FLAG_EN
  ,
  output logic              fifo_ovf
`endif
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] C_AFULL = PTR_W'(AFULL_LEVEL);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_count;
  logic             r_empty;
  logic             r_afull;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [PTR_W-1:0] w_count_nxt;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                    (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]);
  assign w_rd_acc = rd_en && !w_empty;
  // A same-edge read frees a slot, so a write into a full FIFO still lands.
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + C_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + C_ONE;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_afull <= (w_count_nxt >= C_AFULL);
    end
  end

  assign fifo_empty = r_empty;
  assign fifo_afull = r_afull;

`ifdef AXIS_FIFO_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (wr_en && !w_wr_acc) begin
      r_ovf <= 1'b1;
    end
  end

  assign fifo_ovf = r_ovf;
`endif

  axis_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo_core.sv
//------------------------------------------------------------------------------
// Module  : tb_axis_fifo_core
// Brief   : Scoreboard bench for axis_fifo_core (honours AXIS_FIFO_OVF_FLAG_EN).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_fifo_core;
  import axis_fifo_pkg::*;

  localparam int DEPTH       = 8;
  localparam int AFULL_LEVEL = DEPTH - 2;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  logic  wr_en = 1'b0;
  data_t wr_data = '0;
  logic  rd_en = 1'b0;
  data_t rd_data;
  logic  fifo_empty;
  logic  fifo_afull;
`ifdef AXIS_FIFO_OVF_FLAG_EN
  logic  fifo_ovf;
`endif

  axis_fifo_core #(
    .DEPTH       (DEPTH),
    .DATA_W      (DATA_W_DEF),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_afull (fifo_afull)
`ifdef AXIS_FIFO_OVF_FLAG_EN
    ,
    .fifo_ovf   (fifo_ovf)
`endif
  );

  always #5 clk = ~clk;

  data_t model_q[$];
  data_t exp_q[$];
  data_t exp_rd = '0;
  logic  ovf_model = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, ":empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    check({tag, ":afull"}, 32'(fifo_afull), 32'(model_q.size() >= AFULL_LEVEL));
`ifdef AXIS_FIFO_OVF_FLAG_EN
    check({tag, ":ovf"}, 32'(fifo_ovf), 32'(ovf_model));
`endif
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic we, input data_t wd, input logic re);
    logic rd_acc, wr_acc;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    rd_acc  = re && (model_q.size() != 0);
    wr_acc  = we && ((model_q.size() != DEPTH) || rd_acc);
    if (rd_acc) exp_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(wd);
    if (we && !wr_acc) ovf_model = 1'b1;
    @(posedge clk);
    #1;
    if (rd_acc) exp_rd = exp_q.pop_front();
    check_outputs(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    resetn = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_q.delete();
    exp_q.delete();
    exp_rd    = '0;
    ovf_model = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    do_reset("reset", 5);
    step("idle", 1'b0, '0, 1'b0);

    // Basic ordering
    step("wr1", 1'b1, 16'h1111, 1'b0);
    step("wr2", 1'b1, 16'h2222, 1'b0);
    step("wr3", 1'b1, 16'h3333, 1'b0);
    for (int i = 0; i < 3; i++) step("rd_basic", 1'b0, '0, 1'b1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, data_t'(16'hA000 + i), 1'b0);
    step("drop", 1'b1, 16'hBEEF, 1'b0);
    step("full_rw", 1'b1, 16'hA008, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);

    // Sustained simultaneous read/write across pointer wrap
    for (int i = 0; i < 3; i++) step("pre3", 1'b1, data_t'(16'hC000 + i), 1'b0);
    for (int i = 0; i < 20; i++) step("rw20", 1'b1, data_t'(16'hD000 + i), 1'b1);
    for (int i = 0; i < 3; i++) step("post3", 1'b0, '0, 1'b1);

    // Read while empty alongside a write: no bypass
    step("empty_rw", 1'b1, 16'h5A5A, 1'b1);
    step("rd_5a5a", 1'b0, '0, 1'b1);
    step("rd_empty", 1'b0, '0, 1'b1);

    // Mid-stream reset discards contents
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, data_t'(16'hE000 + i), 1'b0);
    do_reset("mid_reset", 1);
    step("rd_after_rst", 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)));
    while (model_q.size() != 0) step("final_drain", 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
